// File: rtl/fetch_stage_pq.sv
// fetch_stage_pq: sequential fetch with an in-order prefetch queue.
// Define FETCH_PQ_BYPASS_EN to forward a response straight to decode.
module fetch_stage_pq #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            en_reg,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];
  logic [XLEN-1:0] ins_q [DEPTH];
  logic [XLEN-1:0] ins_d [DEPTH];
  logic [DEPTH-1:0] fill_q, fill_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] alloc_q, alloc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] n_filled;
  logic issue, rsp_fill, pop, byp, head_full;

  assign mem_req_valid = !reset && !redirect
                       && (cnt_q < CW'(DEPTH));
  assign mem_req_addr = fpc_q;
  assign issue = mem_req_valid && mem_req_ready;
  assign rsp_fill = mem_rsp_valid && (disc_q == '0);
  assign head_full = fill_q[head_q];

`ifdef FETCH_PQ_BYPASS_EN
  // head unfilled means nothing is filled, so alloc == head
  assign byp = rsp_fill && !head_full && (cnt_q != '0);
`else
  assign byp = 1'b0;
`endif

  assign out_valid = head_full || byp;
  assign out_instr = head_full ? ins_q[head_q]
                   : (byp ? mem_rsp_data : '0);
  assign out_pc = out_valid ? pc_q[head_q] : '0;
  assign out_pc_plus4 = out_valid
                      ? pc_q[head_q] + XLEN'(4) : '0;
  assign pop = out_valid && en_reg && !redirect;

  always_comb begin
    fpc_d = fpc_q;
    pc_d = pc_q;
    ins_d = ins_q;
    fill_d = fill_q;
    head_d = head_q;
    tail_d = tail_q;
    alloc_d = alloc_q;
    cnt_d = cnt_q;
    disc_d = disc_q;
    n_filled = '0;
    for (int i = 0; i < DEPTH; i++)
      n_filled = n_filled + CW'(fill_q[i]);
    if (redirect) begin
      fpc_d = redirect_pc;
      fill_d = '0;
      head_d = '0;
      tail_d = '0;
      alloc_d = '0;
      cnt_d = '0;
      // every owed response, minus the one arriving now
      disc_d = disc_q + (cnt_q - n_filled)
             - CW'(mem_rsp_valid);
    end else begin
      if (mem_rsp_valid) begin
        if (!rsp_fill) begin
          disc_d = disc_q - CW'(1);
        end else begin
          ins_d[alloc_q] = mem_rsp_data;
          fill_d[alloc_q] = 1'b1;
          alloc_d = alloc_q + AW'(1);
        end
      end
      if (pop) begin
        fill_d[head_q] = 1'b0;
        head_d = head_q + AW'(1);
      end
      if (issue) begin
        pc_d[tail_q] = fpc_q;
        fill_d[tail_q] = 1'b0;
        tail_d = tail_q + AW'(1);
        fpc_d = fpc_q + XLEN'(4);
      end
      cnt_d = cnt_q + CW'(issue) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q <= RESET_PC;
      fill_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      alloc_q <= '0;
      cnt_q <= '0;
      disc_q <= '0;
    end else begin
      fpc_q <= fpc_d;
      fill_q <= fill_d;
      head_q <= head_d;
      tail_q <= tail_d;
      alloc_q <= alloc_d;
      cnt_q <= cnt_d;
      disc_q <= disc_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    ins_q <= ins_d;
  end
endmodule

// File: tb/tb_fetch_stage_pq.sv
// tb_fetch_stage_pq: fetch queue bench with a latency memory
// and a queue-based reference model.
module tb_fetch_stage_pq;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset, redirect, en_reg, mem_req_ready, mem_rsp_valid;
  logic [31:0] redirect_pc, mem_rsp_data;
  logic mem_req_valid, out_valid;
  logic [31:0] mem_req_addr, out_instr, out_pc, out_pc_plus4;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage_pq #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect),
    .redirect_pc(redirect_pc), .en_reg(en_reg),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
  mreq_t mq[$];
  ent_t mdl[$];
  logic [31:0] m_pc;
  int m_disc = 0;
  int lat = 1;
  int cyc = 0;
  logic o_rv, o_ov, o_hs, o_rsp;
  logic [31:0] o_ra, o_oi, o_op, o_op4;
  logic e_rv, e_ov;
  logic [31:0] e_oi, e_op, e_op4;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // one clock: memory drives, outputs sampled, model advanced
  task automatic cycle();
    bit fill, byp, pop, done;
    int uf;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = instr_of(mq[0].addr);
    end
    #1;
    o_rv = mem_req_valid; o_ra = mem_req_addr;
    o_ov = out_valid; o_oi = out_instr;
    o_op = out_pc; o_op4 = out_pc_plus4;
    o_rsp = mem_rsp_valid;
    o_hs = mem_req_valid && mem_req_ready;
    fill = mem_rsp_valid && m_disc == 0;
    e_rv = !reset && !redirect && mdl.size() < DEPTH;
    e_ov = mdl.size() > 0 && mdl[0].filled;
    byp = 1'b0;
`ifdef FETCH_PQ_BYPASS_EN
    if (!e_ov && fill && mdl.size() > 0) begin
      e_ov = 1'b1;
      byp = 1'b1;
    end
`endif
    e_oi = !e_ov ? 32'h0 : (byp ? mem_rsp_data : mdl[0].instr);
    e_op = e_ov ? mdl[0].pc : 32'h0;
    e_op4 = e_ov ? mdl[0].pc + 32'd4 : 32'h0;
    @(posedge clk);
    #1;
    if (reset) begin
      mdl.delete(); mq.delete(); m_disc = 0; m_pc = 32'h0;
    end else begin
      if (o_rsp) void'(mq.pop_front());
      if (o_hs) mq.push_back('{o_ra, cyc + lat});
      if (redirect) begin
        uf = 0;
        foreach (mdl[i]) if (!mdl[i].filled) uf++;
        m_disc = m_disc + uf - (o_rsp ? 1 : 0);
        mdl.delete();
        m_pc = redirect_pc;
      end else begin
        pop = e_ov && en_reg;
        if (o_rsp) begin
          if (m_disc > 0) m_disc--;
          else begin
            done = 1'b0;
            for (int i = 0; i < mdl.size(); i++)
              if (!done && !mdl[i].filled) begin
                mdl[i].filled = 1'b1;
                mdl[i].instr = mem_rsp_data;
                done = 1'b1;
              end
          end
        end
        if (pop) void'(mdl.pop_front());
        if (e_rv && mem_req_ready) begin
          mdl.push_back('{m_pc, 32'h0, 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int l);
    reset = 1'b1; redirect = 1'b0; en_reg = 1'b0;
    mem_req_ready = 1'b1; lat = l;
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    n_cmp++;
    if (o_rv !== 1'b0) begin
      n_bad++; $display("FAIL reset_req_valid got=%0d exp=0", o_rv);
    end
    n_cmp++;
    if ({o_ov, o_oi, o_op, o_op4} !== 97'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%0d i=%h pc=%h pc4=%h exp=0",
               o_ov, o_oi, o_op, o_op4);
    end
    cycle();
    n_cmp++;
    if (o_rv !== 1'b1 || o_ra !== 32'h0) begin
      n_bad++;
      $display("FAIL first_req got v=%0d a=%h exp v=1 a=0", o_rv, o_ra);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pcs[$];
    int cs[$];
    do_reset(1);
    en_reg = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (o_ov) begin
        pcs.push_back(o_op);
        cs.push_back(cyc);
        n_cmp++;
        if (o_op4 !== o_op + 32'd4) begin
          n_bad++;
          $display("FAIL stream_pc4 got=%h exp=%h", o_op4, o_op + 32'd4);
        end
      end
    end
    n_cmp++;
    if (pcs.size() < 4) begin
      n_bad++; $display("FAIL stream_count got=%0d exp>=4", pcs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (pcs[i] !== 32'(4 * i) || cs[i] != cs[0] + i) begin
          n_bad++;
          $display("FAIL stream_seq%0d got pc=%h cyc=%0d exp pc=%h cyc=%0d",
                   i, pcs[i], cs[i], 32'(4 * i), cs[0] + i);
        end
      end
    end
  endtask

  task automatic test_stall();
    int nhs;
    logic [31:0] pops[$];
    logic [31:0] first_a;
    bit got_a;
    do_reset(1);
    nhs = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_hs) nhs++;
    end
    n_cmp++;
    if (nhs != 4 || o_rv !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_full got reqs=%0d v=%0d exp reqs=4 v=0", nhs, o_rv);
    end
    en_reg = 1'b1;
    got_a = 1'b0;
    first_a = 32'h0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (o_ov) pops.push_back(o_op);
      if (o_hs && !got_a) begin
        first_a = o_ra;
        got_a = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (pops.size() <= i || pops[i] !== 32'(4 * i)) begin
        n_bad++;
        $display("FAIL stall_pop%0d got=%h exp=%h", i,
                 pops.size() > i ? pops[i] : 32'hX, 32'(4 * i));
      end
    end
    n_cmp++;
    if (!got_a || first_a !== 32'd16) begin
      n_bad++;
      $display("FAIL stall_resume got=%h exp=00000010", first_a);
    end
  endtask

  task automatic test_redirect();
    int nhs;
    bit seen, stale;
    logic [31:0] first_pc, first_i;
    do_reset(3);
    en_reg = 1'b1;
    nhs = 0;
    for (int i = 0; i < 10 && nhs < 3; i++) begin
      cycle();
      if (o_hs) nhs++;
    end
    n_cmp++;
    if (nhs != 3) begin
      n_bad++; $display("FAIL redir_inflight got=%0d exp=3", nhs);
    end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    n_cmp++;
    if (o_rv !== 1'b0) begin
      n_bad++; $display("FAIL redir_req_valid got=%0d exp=0", o_rv);
    end
    seen = 1'b0; stale = 1'b0;
    first_pc = 32'h0; first_i = 32'h0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (o_ov) begin
        if (!seen) begin
          first_pc = o_op; first_i = o_oi; seen = 1'b1;
        end
        if (o_op < 32'h100 || o_oi !== instr_of(o_op)) stale = 1'b1;
      end
    end
    n_cmp++;
    if (!seen || first_pc !== 32'h100 || first_i !== instr_of(32'h100)) begin
      n_bad++;
      $display("FAIL redir_first got pc=%h i=%h exp pc=00000100 i=%h",
               first_pc, first_i, instr_of(32'h100));
    end
    n_cmp++;
    if (stale) begin
      n_bad++; $display("FAIL redir_stale got=1 exp=0");
    end
  endtask

  task automatic test_collide();
    bit seen;
    logic [31:0] fp;
    do_reset(1);
    en_reg = 1'b1;
    repeat (4) cycle();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0;
    n_cmp++;
    if (o_ov !== 1'b1 || o_rsp !== 1'b1 || o_rv !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_cycle got ov=%0d rsp=%0d rv=%0d exp 1 1 0",
               o_ov, o_rsp, o_rv);
    end
    cycle();
    n_cmp++;
    if (o_ov !== 1'b0 || o_ra !== 32'h200) begin
      n_bad++;
      $display("FAIL collide_empty got ov=%0d a=%h exp ov=0 a=00000200",
               o_ov, o_ra);
    end
    seen = 1'b0; fp = 32'h0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cycle();
      if (o_ov) begin seen = 1'b1; fp = o_op; end
    end
    n_cmp++;
    if (!seen || fp !== 32'h200) begin
      n_bad++; $display("FAIL collide_next got=%h exp=00000200", fp);
    end
  endtask

  task automatic test_ready_stall();
    do_reset(1);
    repeat (2) cycle();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (o_rv !== 1'b1 || o_ra !== 32'h8) begin
        n_bad++;
        $display("FAIL rdy_hold%0d got v=%0d a=%h exp v=1 a=00000008",
                 i, o_rv, o_ra);
      end
    end
    mem_req_ready = 1'b1;
    cycle();
    n_cmp++;
    if (o_hs !== 1'b1 || o_ra !== 32'h8) begin
      n_bad++;
      $display("FAIL rdy_accept got hs=%0d a=%h exp hs=1 a=00000008",
               o_hs, o_ra);
    end
    cycle();
    n_cmp++;
    if (o_ra !== 32'hC) begin
      n_bad++; $display("FAIL rdy_next got=%h exp=0000000c", o_ra);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset(1);
    en_reg = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    cycle();
    n_cmp++;
    if (o_hs !== 1'b1 || o_ra !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_req0 got=%h exp=fffffffc", o_ra);
    end
    cycle();
    n_cmp++;
    if (o_ra !== 32'h0) begin
      n_bad++; $display("FAIL wrap_req1 got=%h exp=00000000", o_ra);
    end
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cycle();
      seen = o_ov;
    end
    n_cmp++;
    if (!seen || o_op !== 32'hFFFF_FFFC || o_op4 !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_out0 got pc=%h pc4=%h exp fffffffc 00000000",
               o_op, o_op4);
    end
    cycle();
    n_cmp++;
    if (o_ov !== 1'b1 || o_op !== 32'h0 || o_op4 !== 32'h4) begin
      n_bad++;
      $display("FAIL wrap_out1 got v=%0d pc=%h pc4=%h exp 1 0 4",
               o_ov, o_op, o_op4);
    end
  endtask

  task automatic test_random();
    for (int l = 1; l <= 3; l++) begin
      do_reset(l);
      for (int i = 0; i < 400; i++) begin
        reset = ($urandom_range(199) == 0);
        redirect = ($urandom_range(15) == 0);
        redirect_pc = $urandom & 32'hFFFF_FFFC;
        en_reg = ($urandom_range(3) != 0);
        mem_req_ready = ($urandom_range(3) != 0);
        cycle();
        n_cmp++;
        if (o_rv !== e_rv || (e_rv && o_ra !== m_pc - (o_hs ? 32'd4 : 32'd0)
                               && !redirect)) begin
          n_bad++;
          $display("FAIL rnd_req l=%0d i=%0d got v=%0d a=%h exp v=%0d",
                   l, i, o_rv, o_ra, e_rv);
        end
        n_cmp++;
        if ({o_ov, o_oi, o_op, o_op4} !== {e_ov, e_oi, e_op, e_op4}
            || (o_ov && o_oi !== instr_of(o_op))) begin
          n_bad++;
          $display("FAIL rnd_out l=%0d i=%0d got %0d %h %h %h exp %0d %h %h %h",
                   l, i, o_ov, o_oi, o_op, o_op4, e_ov, e_oi, e_op, e_op4);
        end
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    en_reg = 1'b0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    m_pc = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_collide();
    test_ready_stall();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
